text_buffer: RTL and testbench



---
 rtl/text_buffer.sv | 180 ++++++++++++++++++
 tb/tb_text_buffer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_buffer.sv
// ---------------------------------------------------------------------------
// text_buffer
//   Character-cell screen memory for the VGA text renderer. A byte stream
//   (printable ASCII plus a few control codes) arrives over a valid/ready
//   write port and is placed at a cursor. Every cycle the renderer's pixel
//   position (x, y) is mapped onto a COLS x ROWS grid of 8x16 cells located
//   at (X_ORG, Y_ORG). The code of the cell under that pixel is presented on
//   ascii_code one cycle later. Pixels outside the window read as BLANK.
//
// Ports
//   clk         pixel-domain clock
//   reset_n     asynchronous reset, active low
//   wr_data     byte to store, or a control code
//   wr_valid    wr_data is valid
//   wr_ready    buffer accepts a byte this cycle (registered, FSM-state only)
//   x, y        current pixel column / row
//   ascii_code  cell code for (x, y), one cycle latency
//   cur_col     cursor column
//   cur_row     cursor row
// ---------------------------------------------------------------------------
module text_buffer #(
    parameter int          COLS  = 32,
    parameter int          ROWS  = 4,
    parameter int          X_ORG = 192,
    parameter int          Y_ORG = 208,
    parameter logic [7:0]  BLANK = 8'h20
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [7:0]                wr_data,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [9:0]                x,
    input  logic [9:0]                y,
    output logic [7:0]                ascii_code,
    output logic [$clog2(COLS)-1:0]   cur_col,
    output logic [$clog2(ROWS)-1:0]   cur_row
);

    localparam int CW    = $clog2(COLS);
    localparam int RW    = $clog2(ROWS);
    localparam int AW    = CW + RW;
    localparam int CELLS = COLS * ROWS;

    localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(CELLS - 1);
    localparam logic [RW-1:0] ROW_ONE   = RW'(1);

    localparam logic [9:0] X_LO = 10'(X_ORG);
    localparam logic [9:0] X_HI = 10'(X_ORG + 8 * COLS);
    localparam logic [9:0] Y_LO = 10'(Y_ORG);
    localparam logic [9:0] Y_HI = 10'(Y_ORG + 16 * ROWS);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t         state_q,     state_d;
    logic [AW-1:0]  clr_cnt_q,   clr_cnt_d;
    // Cursor kept as the linear cell address {row, col}; a +1/-1 on it
    // gives the column wrap into the next/previous row for free.
    logic [AW-1:0]  cur_q,       cur_d;
    logic           wr_ready_q,  wr_ready_d;
    logic [7:0]     ascii_q,     ascii_d;

    logic [7:0]     mem [CELLS];
    logic           mem_we_s;
    logic [AW-1:0]  mem_waddr_s;
    logic [7:0]     mem_wdata_s;

    logic           accept_s;
    logic           in_win_s;
    logic [CW-1:0]  rd_col_s;
    logic [RW-1:0]  rd_row_s;

    // Next-state logic: clear sweep, byte acceptance and cursor movement.
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        cur_d       = cur_q;
        mem_we_s    = 1'b0;
        mem_waddr_s = cur_q;
        mem_wdata_s = BLANK;
        accept_s    = wr_valid & wr_ready_q;

        case (state_q)
            ST_CLEAR: begin
                mem_we_s    = 1'b1;
                mem_waddr_s = clr_cnt_q;
                mem_wdata_s = BLANK;
                if (clr_cnt_q == ADDR_LAST) begin
                    state_d   = ST_IDLE;
                    clr_cnt_d = '0;
                    cur_d     = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + ADDR_ONE;
                end
            end
            ST_IDLE: begin
                if (accept_s) begin
                    if ((wr_data >= 8'h20) && (wr_data <= 8'h7E)) begin
                        mem_we_s    = 1'b1;
                        mem_waddr_s = cur_q;
                        mem_wdata_s = wr_data;
                        cur_d       = cur_q + ADDR_ONE;
                    end else if (wr_data == 8'h0D) begin
                        cur_d = {cur_q[AW-1:CW] + ROW_ONE, {CW{1'b0}}};
                    end else if (wr_data == 8'h08) begin
                        if (cur_q != '0) begin
                            cur_d       = cur_q - ADDR_ONE;
                            mem_we_s    = 1'b1;
                            mem_waddr_s = cur_q - ADDR_ONE;
                            mem_wdata_s = BLANK;
                        end else begin
                            cur_d = cur_q;
                        end
                    end else if (wr_data == 8'h0C) begin
                        state_d   = ST_CLEAR;
                        clr_cnt_d = '0;
                    end else begin
                        // Unsupported codes are consumed without effect.
                        cur_d = cur_q;
                    end
                end else begin
                    cur_d = cur_q;
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_cnt_d = '0;
            end
        endcase

        // Ready is a registered function of the next state only.
        wr_ready_d = (state_d == ST_IDLE);
    end

    // Read-address decode of the pixel position into a cell address.
    always_comb begin
        in_win_s = (x >= X_LO) && (x < X_HI) && (y >= Y_LO) && (y < Y_HI);
        rd_col_s = CW'((x - X_LO) >> 4'd3);
        rd_row_s = RW'((y - Y_LO) >> 4'd4);
        if (in_win_s) begin
            ascii_d = mem[{rd_row_s, rd_col_s}];
        end else begin
            ascii_d = BLANK;
        end
    end

    // Control and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_CLEAR;
            clr_cnt_q  <= '0;
            cur_q      <= '0;
            wr_ready_q <= 1'b0;
            ascii_q    <= BLANK;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            cur_q      <= cur_d;
            wr_ready_q <= wr_ready_d;
            ascii_q    <= ascii_d;
        end
    end

    // Cell storage write port; a same-cycle read of the cell sees old data.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem[mem_waddr_s] <= mem_wdata_s;
        end
    end

    assign wr_ready   = wr_ready_q;
    assign ascii_code = ascii_q;
    assign cur_col    = cur_q[CW-1:0];
    assign cur_row    = cur_q[AW-1:CW];

endmodule

// File: tb/tb_text_buffer.sv
// ---------------------------------------------------------------------------
// tb_text_buffer
//   Scoreboard bench for text_buffer. Each stimulus cycle drives the write
//   port and a pixel position, updates a cell-array model of the screen and
//   queues the outputs expected after the next clock edge. A monitor on the
//   falling edge pops and compares them.
// ---------------------------------------------------------------------------
module tb_text_buffer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [9:0] x = 10'd0;
    logic [9:0] y = 10'd0;
    logic [7:0] ascii_code;
    logic [4:0] cur_col;
    logic [1:0] cur_row;

    text_buffer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .x          (x),
        .y          (y),
        .ascii_code (ascii_code),
        .cur_col    (cur_col),
        .cur_row    (cur_row)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         due;
        int         kind;   // 0 ascii_code, 1 wr_ready, 2 cursor {row,col}
        logic [7:0] exp;
    } item_t;

    item_t sb_q[$];
    int    errors = 0;
    int    checks = 0;

    // Screen model: 4 rows x 32 columns of 8x16 cells at (192, 208).
    logic [7:0] m_mem   [128];
    bit         m_known [128];
    int         m_row = 0;
    int         m_col = 0;
    int         m_busy = 0;    // clear-sweep cycles still to run

    function automatic void push(int due, int kind, logic [7:0] e);
        item_t it;
        it.due  = due;
        it.kind = kind;
        it.exp  = e;
        sb_q.push_back(it);
    endfunction

    // Monitor: compare every expectation that has come due.
    always @(negedge clk) begin
        item_t      it;
        logic [7:0] act;
        string      nm;
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            it = sb_q.pop_front();
            case (it.kind)
                0:       begin act = ascii_code;                 nm = "ascii_code"; end
                1:       begin act = {7'b0, wr_ready};           nm = "wr_ready";   end
                default: begin act = {1'b0, cur_row, cur_col};   nm = "cursor";     end
            endcase
            checks++;
            if (act !== it.exp) begin
                errors++;
                $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, it.exp);
            end
        end
    end

    function automatic void apply_byte(logic [7:0] d);
        if (d >= 8'h20 && d <= 8'h7E) begin
            m_mem[m_row * 32 + m_col]   = d;
            m_known[m_row * 32 + m_col] = 1'b1;
            m_col++;
            if (m_col == 32) begin
                m_col = 0;
                m_row = (m_row + 1) % 4;
            end
        end else if (d == 8'h0D) begin
            m_col = 0;
            m_row = (m_row + 1) % 4;
        end else if (d == 8'h08) begin
            if (!(m_row == 0 && m_col == 0)) begin
                if (m_col == 0) begin
                    m_col = 31;
                    m_row = m_row - 1;
                end else begin
                    m_col = m_col - 1;
                end
                m_mem[m_row * 32 + m_col]   = 8'h20;
                m_known[m_row * 32 + m_col] = 1'b1;
            end
        end else if (d == 8'h0C) begin
            m_busy = 128;
        end
    endfunction

    // One clock of stimulus plus the expectations for the following edge.
    task automatic cycle(bit v, logic [7:0] d, int xx, int yy);
        int idx;
        wr_valid = v;
        wr_data  = d;
        x        = xx[9:0];
        y        = yy[9:0];
        if (xx >= 192 && xx < 448 && yy >= 208 && yy < 272) begin
            idx = ((yy - 208) / 16) * 32 + (xx - 192) / 8;
            if (m_known[idx]) push(cyc + 1, 0, m_mem[idx]);
        end else begin
            push(cyc + 1, 0, 8'h20);
        end
        if (m_busy > 0) begin
            idx = 128 - m_busy;
            m_mem[idx]   = 8'h20;
            m_known[idx] = 1'b1;
            m_busy--;
            if (m_busy == 0) begin
                m_row = 0;
                m_col = 0;
            end
        end else if (v) begin
            apply_byte(d);
        end
        push(cyc + 1, 1, (m_busy == 0) ? 8'h01 : 8'h00);
        push(cyc + 1, 2, {1'b0, m_row[1:0], m_col[4:0]});
        @(posedge clk);
        #1;
    endtask

    function automatic int rx();
        return int'($urandom_range(500, 150));
    endfunction

    function automatic int ry();
        return int'($urandom_range(300, 180));
    endfunction

    task automatic send(logic [7:0] d);
        cycle(1'b1, d, rx(), ry());
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, rx(), ry());
    endtask

    task automatic scan_all();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 32; c++)
                cycle(1'b0, 8'h00, 192 + c * 8 + int'($urandom_range(7, 0)),
                      208 + r * 16 + int'($urandom_range(15, 0)));
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        reset_n  = 1'b0;
        wr_valid = 1'b0;
        #1;
        push(cyc + 1, 0, 8'h20);
        push(cyc + 1, 1, 8'h00);
        push(cyc + 1, 2, 8'h00);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        m_busy  = 128;
        m_row   = 0;
        m_col   = 0;
    endtask

    initial begin
        logic [7:0] d;
        int         r;
        for (int i = 0; i < 128; i++) m_known[i] = 1'b0;

        // Power-up clear, then every cell reads blank.
        do_reset();
        idle(130);
        scan_all();

        // "AB", reads of both cells, and a read/write collision.
        send(8'h41);
        send(8'h42);
        cycle(1'b0, 8'h00, 200, 210);
        cycle(1'b0, 8'h00, 196, 210);
        cycle(1'b1, 8'h43, 208, 208);
        cycle(1'b0, 8'h00, 208, 208);
        send(8'h08);
        send(8'h08);
        send(8'h08);
        send(8'h08);            // already at (0,0): no effect
        send(8'h0A);
        send(8'h7F);
        send(8'hFF);
        send(8'h00);
        cycle(1'b0, 8'h00, 192, 208);

        // Full row then backspace across the row boundary.
        for (int i = 0; i < 32; i++) send(8'h58);
        send(8'h08);
        cycle(1'b0, 8'h00, 440, 210);
        cycle(1'b0, 8'h00, 432, 210);

        // Wrap from (3,31) to (0,0); carriage return from (2,5).
        send(8'h0D);
        send(8'h0D);
        send(8'h0D);
        for (int i = 0; i < 31; i++) send(8'h61 + 8'(i % 26));
        send(8'h5A);
        cycle(1'b0, 8'h00, 447, 271);
        send(8'h0D);
        send(8'h0D);
        for (int i = 0; i < 5; i++) send(8'h30 + 8'(i));
        send(8'h0D);

        // Window boundaries.
        cycle(1'b0, 8'h00, 100, 210);
        cycle(1'b0, 8'h00, 200, 300);
        cycle(1'b0, 8'h00, 191, 208);
        cycle(1'b0, 8'h00, 192, 207);
        cycle(1'b0, 8'h00, 448, 208);
        cycle(1'b0, 8'h00, 447, 272);
        cycle(1'b0, 8'h00, 192, 208);
        cycle(1'b0, 8'h00, 447, 271);

        // Form feed mid-text with wr_valid held high throughout the clear.
        send(8'h4B);
        send(8'h0C);
        for (int i = 0; i < 132; i++) cycle(1'b1, 8'h41, rx(), ry());
        scan_all();

        // Reset pulsed in the middle of a clear restarts the full sweep.
        send(8'h0C);
        idle(50);
        do_reset();
        idle(130);
        scan_all();

        // Randomised byte stream with random pixel reads.
        for (int i = 0; i < 700; i++) begin
            r = int'($urandom_range(15, 0));
            case (r)
                0:       d = 8'h0D;
                1:       d = 8'h08;
                2:       d = ($urandom_range(7, 0) == 0) ? 8'h0C : 8'h0A;
                3:       d = 8'($urandom);
                default: d = 8'h20 + 8'($urandom_range(94, 0));
            endcase
            cycle(1'($urandom), d, rx(), ry());
        end
        idle(130);
        scan_all();

        // Drain the scoreboard within a bounded number of edges.
        wr_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d expected=0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
